// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// pc_sequencer_pkg : shared FSM encoding and widths for the PC sequencer
// Revision: 1.0
// =============================================================================
package pc_sequencer_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned TMO_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_next_pc.sv
`default_nettype none
// =============================================================================
// next_pc_select : prioritised next-PC mux (trap > jmp > br > pc+4) with
// alignment check on jump/branch targets. Revision: 1.0
// =============================================================================
module next_pc_select
  import pc_sequencer_pkg::*;
#(
  parameter logic [INSTR_W-1:0] TRAP_VECTOR = 32'h0000_0080
) (
  input  logic [INSTR_W-1:0] pc,
  input  logic               trap,
  input  logic               jmp,
  input  logic [INSTR_W-1:0] jmp_target,
  input  logic               br_taken,
  input  logic [INSTR_W-1:0] br_target,
  output logic [INSTR_W-1:0] target,
  output logic               misaligned
);

  always_comb begin
    target     = pc + 32'd4;
    misaligned = 1'b0;
    if (trap) begin
      target = TRAP_VECTOR;
    end else if (jmp) begin
      if (jmp_target[1:0] != 2'b00) begin
        target     = TRAP_VECTOR;
        misaligned = 1'b1;
      end else begin
        target = jmp_target;
      end
    end else if (br_taken) begin
      if (br_target[1:0] != 2'b00) begin
        target     = TRAP_VECTOR;
        misaligned = 1'b1;
      end else begin
        target = br_target;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// =============================================================================
// pc_sequencer : fetch / execute / PC-update sequencer with memory timeout
// Revision: 1.0
// =============================================================================
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [INSTR_W-1:0] TRAP_VECTOR = 32'h0000_0080,
  parameter int unsigned        MEM_TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RES_N,
  input  logic [INSTR_W-1:0] pc,
  output logic [INSTR_W-1:0] pc_next,
  output logic               pc_write,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               trap,
  input  logic               jmp,
  input  logic               br_taken,
  input  logic [INSTR_W-1:0] jmp_target,
  input  logic [INSTR_W-1:0] br_target,
  input  logic               stall,
  output logic               fault
);

  localparam logic [TMO_CNT_W-1:0] C_TMO_LIMIT = MEM_TIMEOUT[TMO_CNT_W-1:0];

  state_e                 state_q, state_d;
  logic [INSTR_W-1:0]     pc_next_q, pc_next_d;
  logic                   pc_write_q, pc_write_d;
  logic                   imem_req_q, imem_req_d;
  logic [INSTR_W-1:0]     instr_q, instr_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   fault_q, fault_d;
  logic [TMO_CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [INSTR_W-1:0]     w_target;
  logic                   w_misaligned;
  logic [TMO_CNT_W-1:0]   w_tmo_inc;

  next_pc_select #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_pc_select (
    .pc         (pc),
    .trap       (trap),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .target     (w_target),
    .misaligned (w_misaligned)
  );

  assign w_tmo_inc = tmo_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    pc_next_d  = pc_next_q;
    pc_write_d = 1'b0;
    instr_d    = instr_q;
    fault_d    = 1'b0;
    tmo_cnt_d  = tmo_cnt_q;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        tmo_cnt_d = '0;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_ack) begin
          instr_d   = imem_rdata;
          tmo_cnt_d = '0;
          state_d   = ST_EXEC;
        end else if (w_tmo_inc == C_TMO_LIMIT) begin
          fault_d   = 1'b1;
          pc_next_d = TRAP_VECTOR;
          tmo_cnt_d = '0;
          state_d   = ST_UPDATE;
        end else begin
          tmo_cnt_d = w_tmo_inc;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          pc_next_d = w_target;
          fault_d   = w_misaligned;
          state_d   = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        // The strobe is registered, so leave only after it has been seen,
        // guaranteeing the next fetch uses the freshly written PC.
        if (pc_write_q) begin
          state_d = ST_FETCH;
        end else if (!stall) begin
          pc_write_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    imem_req_d    = (state_d == ST_FETCH) || (state_d == ST_WAIT);
    instr_valid_d = (state_d == ST_EXEC);
  end

  always_ff @(posedge CLK) begin
    if (!RES_N) begin
      state_q       <= ST_IDLE;
      pc_next_q     <= '0;
      pc_write_q    <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_next_q     <= pc_next_d;
      pc_write_q    <= pc_write_d;
      imem_req_q    <= imem_req_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign pc_next     = pc_next_q;
  assign pc_write    = pc_write_q;
  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_req_q ? pc : '0;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// =============================================================================
// tb_pc_sequencer : scoreboard bench for pc_sequencer
// Revision: 1.0
// =============================================================================
module tb_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic        flt;
  } exp_t;

  logic        clk = 1'b0;
  logic        res_n;
  logic [31:0] pc_r;
  logic [31:0] pc_init;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        trap;
  logic        jmp;
  logic        br_taken;
  logic [31:0] jmp_target;
  logic [31:0] br_target;
  logic        stall;
  logic        fault;

  int   n_vec = 0;
  int   n_err = 0;
  int   pcw_cnt = 0;
  int   flt_cnt = 0;
  int   flt_since = 0;
  logic prev_pcw = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .CLK         (clk),
    .RES_N       (res_n),
    .pc          (pc_r),
    .pc_next     (pc_next),
    .pc_write    (pc_write),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .trap        (trap),
    .jmp         (jmp),
    .br_taken    (br_taken),
    .jmp_target  (jmp_target),
    .br_target   (br_target),
    .stall       (stall),
    .fault       (fault)
  );

  // program_counter stand-in
  always @(posedge clk) begin
    if (!res_n)        pc_r <= pc_init;
    else if (pc_write) pc_r <= pc_next;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fault === 1'b1) begin
      flt_cnt++;
      flt_since++;
    end
    if (pc_write === 1'b1) begin
      check_eq("pcw_single", {31'b0, prev_pcw}, 32'd0);
      check_eq("sb_nonempty", {31'b0, (sb_q.size() != 0)}, 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check_eq("pc_next", pc_next, mon_e.pc);
        check_eq("fault_pulses", flt_since, {31'b0, mon_e.flt});
      end
      flt_since = 0;
      pcw_cnt++;
    end
    prev_pcw = pc_write;
  end

  task automatic push_exp(input logic [31:0] p, input logic f);
    exp_t e;
    e.pc  = p;
    e.flt = f;
    sb_q.push_back(e);
  endtask

  task automatic do_reset(input logic [31:0] p0);
    @(negedge clk);
    res_n = 1'b0; pc_init = p0; imem_ack = 1'b0; exec_done = 1'b0;
    trap = 1'b0; jmp = 1'b0; br_taken = 1'b0; stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pc_write", pc_write, 0);
    check_eq("rst_imem_req", imem_req, 0);
    check_eq("rst_instr_valid", instr_valid, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_pc_next", pc_next, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_imem_addr", imem_addr, 0);
    res_n = 1'b1;
  endtask

  task automatic wait_req();
    int k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("fetch_req", imem_req, 1);
  endtask

  task automatic run_instr(input logic [31:0] rdata, input int ack_dly,
                           input logic t, input logic j, input logic b,
                           input logic [31:0] jt, input logic [31:0] bt,
                           input int stall_cyc, input logic noise,
                           input logic [31:0] exp_pc, input logic exp_flt,
                           output int lat);
    logic [31:0] fpc;
    int k;
    lat = 0;
    wait_req();
    fpc = pc_r;
    check_eq("fetch_addr", imem_addr, fpc);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      lat++;
      check_eq("wait_req", imem_req, 1);
      check_eq("wait_addr", imem_addr, fpc);
    end
    imem_ack = 1'b1; imem_rdata = rdata;
    @(negedge clk);
    lat++;
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    check_eq("instr_valid", instr_valid, 1);
    check_eq("instr", instr, rdata);
    check_eq("exec_req", imem_req, 0);
    if (noise) begin
      trap = 1'b1; jmp = 1'b1; jmp_target = 32'h3; stall = 1'b1;
      @(negedge clk);
      lat++;
      trap = 1'b0; jmp = 1'b0; stall = 1'b0;
      check_eq("noise_instr", instr, rdata);
      check_eq("noise_valid", instr_valid, 1);
      check_eq("noise_fault", fault, 0);
    end
    trap = t; jmp = j; br_taken = b; jmp_target = jt; br_target = bt; exec_done = 1'b1;
    push_exp(exp_pc, exp_flt);
    @(negedge clk);
    lat++;
    trap = 1'b0; jmp = 1'b0; br_taken = 1'b0; exec_done = 1'b0;
    check_eq("upd_valid", instr_valid, 0);
    check_eq("upd_pcw0", pc_write, 0);
    stall = (stall_cyc > 0);
    for (int i = 0; i < stall_cyc; i++) begin
      @(negedge clk);
      lat++;
      check_eq("stall_pcw", pc_write, 0);
    end
    stall = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      lat++;
      k++;
    end while (pc_write !== 1'b1 && k < 20);
    check_eq("pcw_seen", pc_write, 1);
  endtask

  initial begin
    int lat;
    int n;
    int base;
    res_n = 1'b0; pc_init = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    exec_done = 1'b0; trap = 1'b0; jmp = 1'b0; br_taken = 1'b0;
    jmp_target = 32'h0; br_target = 32'h0; stall = 1'b0;

    do_reset(32'h0);
    // sequential fall-through with two cycles of ack latency
    run_instr(32'h0000_0013, 2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 32'h4, 1'b0, lat);
    run_instr(32'h1111_2222, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 32'h8, 1'b0, lat);
    check_eq("latency_ge4", {31'b0, (lat + 1 >= 4)}, 32'd1);
    run_instr(32'h3333_4444, 1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 0, 1'b0, 32'h100, 1'b0, lat);
    run_instr(32'h5555_6666, 0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 0, 1'b0, 32'h80, 1'b0, lat);
    run_instr(32'h7777_8888, 0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h102, 0, 1'b0, 32'h80, 1'b1, lat);
    run_instr(32'h9999_AAAA, 3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2, 1'b1, 32'h84, 1'b0, lat);
    run_instr(32'hBBBB_CCCC, 0, 1'b0, 1'b1, 1'b1, 32'h101, 32'h200, 0, 1'b0, 32'h80, 1'b1, lat);

    do_reset(32'hFFFF_FFFC);
    run_instr(32'hDDDD_EEEE, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 32'h0, 1'b0, lat);

    // memory never answers
    push_exp(32'h80, 1'b1);
    wait_req();
    n = 0;
    while (imem_req === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("tmo_req_cycles", n, 17);
    check_eq("tmo_fault", fault, 1);
    n = 0;
    while (pc_write !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("tmo_pcw", pc_write, 1);

    // reset while stalled in UPDATE
    wait_req();
    base = pcw_cnt;
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    imem_ack = 1'b0; exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_stall_pcw", pc_write, 0);
    end
    res_n = 1'b0; stall = 1'b0;
    @(negedge clk);
    check_eq("abort_pc_write", pc_write, 0);
    check_eq("abort_imem_req", imem_req, 0);
    check_eq("abort_instr_valid", instr_valid, 0);
    check_eq("abort_fault", fault, 0);
    check_eq("abort_pc_next", pc_next, 0);
    check_eq("abort_instr", instr, 0);
    check_eq("abort_imem_addr", imem_addr, 0);
    res_n = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check_eq("abort_no_pcw", pcw_cnt, base);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter TRAP_VECTOR, default 32'h0000_0080, the PC loaded on trap, fault or memory timeout.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, the maximum wait-for-ack cycles, range 2..255.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-004 SHALL have port RES_N, input, 1 bit: the reset, which is synchronous and active-low.
REQ-005 SHALL have port pc, input, 32 bits: the current PC from program_counter.
REQ-006 SHALL have port pc_next, output, 32 bits: the next PC value, driving program_counter.pcNext.
REQ-007 SHALL have port pc_write, output, 1 bit: the update strobe, driving program_counter.pcWrite.
REQ-008 SHALL have port imem_req, output, 1 bit: the instruction fetch request.
REQ-009 SHALL have port imem_addr, output, 32 bits: the fetch address.
REQ-010 SHALL have ports imem_ack, input, 1 bit, and imem_rdata, input, 32 bits: the fetch acknowledge and its data.
REQ-011 SHALL have port instr, output, 32 bits: the latched instruction.
REQ-012 SHALL have port instr_valid, output, 1 bit: instr is presented to the datapath.
REQ-013 SHALL have port exec_done, input, 1 bit: the datapath has finished the current instruction.
REQ-014 SHALL have ports trap, jmp and br_taken, inputs, 1 bit each, and jmp_target and br_target, inputs, 32 bits each: the flow-change requests and their targets.
REQ-015 SHALL have port stall, input, 1 bit: a hold that blocks the PC update.
REQ-016 SHALL have port fault, output, 1 bit: a one-cycle pulse on a misaligned target or a memory timeout.

Function
REQ-017 SHALL implement the FSM states IDLE, FETCH, WAIT, EXEC and UPDATE.
REQ-018 SHALL move IDLE->FETCH unconditionally one cycle after reset is released.
REQ-019 SHALL, in FETCH, assert imem_req=1 with imem_addr=pc and then go to WAIT; if imem_ack=1 in the same cycle, it SHALL latch imem_rdata and go directly to EXEC.
REQ-020 SHALL, in WAIT, hold imem_req=1 and a stable imem_addr until imem_ack=1; on ack it SHALL latch instr<=imem_rdata and go to EXEC.
REQ-021 SHALL count WAIT cycles; when the count reaches MEM_TIMEOUT with no ack, it SHALL pulse fault, select TRAP_VECTOR and go to UPDATE.
REQ-022 SHALL hold instr_valid=1 throughout EXEC, with instr stable.
REQ-023 SHALL, on the EXEC cycle where exec_done=1, register pc_next using the priority trap > jmp > br_taken > pc+4 and go to UPDATE.
REQ-024 SHALL compute pc+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no fault.
REQ-025 SHALL treat a selected jmp_target or br_target whose bits [1:0] are not 00 as misaligned: it SHALL pulse fault and substitute TRAP_VECTOR.
REQ-026 SHALL, in UPDATE, assert pc_write=1 for exactly one cycle and then go to FETCH, provided stall=0.
REQ-027 SHALL, in UPDATE with stall=1, keep pc_write=0 and stay in UPDATE with pc_next held.
REQ-028 SHALL ignore stall in every state other than UPDATE.
REQ-029 SHALL ignore trap, jmp and br_taken except in the EXEC cycle where exec_done=1.
REQ-030 SHALL register all outputs except imem_addr, which SHALL equal pc combinationally while imem_req=1 and be 0 otherwise.
REQ-031 SHALL give an instruction a latency of at least 4 cycles from FETCH to the PC update with a zero-wait ack and immediate exec_done.

Reset
REQ-032 SHALL, while RES_N=0 at a rising edge, force state=IDLE, pc_next=0, pc_write=0, imem_req=0, instr=0, instr_valid=0, fault=0 and the timeout counter to 0.
REQ-033 SHALL let reset abort any state mid-operation, including WAIT and UPDATE with stall=1; no pc_write pulse SHALL occur on or after the reset edge.

Structure
REQ-034 SHALL place the FSM state encoding, a 3-bit typedef, and the instruction width constant 32 in the shared package.
REQ-035 SHALL place the next-PC select and alignment check in one combinational sub-module named next_pc_select.

Verification
REQ-036 SHALL verify: pc=0, ack after 2 cycles, exec_done with no flow change -> one pc_write pulse with pc_next=32'h4, and imem_req held steady for the 2 wait cycles.
REQ-037 SHALL verify: jmp=1 with jmp_target=32'h100 and br_taken=1 with br_target=32'h200 together -> pc_next=32'h100.
REQ-038 SHALL verify: trap=1 together with jmp=1 -> pc_next=32'h80 and fault=0.
REQ-039 SHALL verify: br_target=32'h102 taken -> fault pulses once and pc_next=32'h80.
REQ-040 SHALL verify: imem_ack never asserted -> fault after 16 WAIT cycles, then pc_write with pc_next=32'h80.
REQ-041 SHALL verify: stall=1 for 3 cycles in UPDATE, then RES_N=0 -> no pc_write at any point, and all outputs 0 on the cycle after the reset edge.
